clk_period_meter: RTL and testbench

Measures a slow, asynchronous clock-like signal in units of the system clock, for example the clk_out produced by the team's clock divider. It reports the period and the high time of one cycle of that signal. The block consumes a divided clock and checks its timing, so it is used for self-test and for debug readout on the board. One measurement is taken per start pulse, and the result is returned over a valid/ready handshake.

---
 rtl/clk_pkg.sv | 17 +
 rtl/sync_edge_det.sv | 31 +++
 rtl/clk_period_meter.sv | 135 +++++++++++++
 tb/tb_clk_period_meter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// Shared definitions for the clock period meter: FSM encoding and default sizing.
package clk_pkg;

  typedef enum logic [2:0] {
    ST_SETTLE = 3'd0,
    ST_IDLE   = 3'd1,
    ST_ARM    = 3'd2,
    ST_HIGH   = 3'd3,
    ST_LOW    = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam int DEFAULT_CNT_W       = 32;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_TIMEOUT     = 100000000;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input followed by a delay flop
// that yields single-cycle rise and fall pulses in the clk domain.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous signal in clk cycles,
// one measurement per start pulse, returned over a valid/ready handshake.
module clk_period_meter
  import clk_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CountOne   = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] counter_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] highTime_q;
  logic             timeout_q;

  logic sigLevelUnused;
  logic sigRise;
  logic sigFall;
  logic atLimit;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_in(sig_in),
    .level   (sigLevelUnused),
    .rise    (sigRise),
    .fall    (sigFall)
  );

  // A high phase of exactly TIMEOUT carries the counter one past the limit into LOW,
  // so the limit test is >= rather than ==.
  assign atLimit = (counter_q >= TimeoutVal);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_SETTLE;
      counter_q  <= '0;
      period_q   <= '0;
      highTime_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (counter_q == SettleLast) begin
            counter_q <= '0;
            state_q   <= ST_IDLE;
          end else begin
            counter_q <= counter_q + CountOne;
          end
        end
        ST_IDLE: begin
          if (start) begin
            counter_q <= CountOne;
            state_q   <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (sigRise) begin
            counter_q <= CountOne;
            state_q   <= ST_HIGH;
          end else if (atLimit) begin
            period_q   <= '0;
            highTime_q <= '0;
            timeout_q  <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            counter_q <= counter_q + CountOne;
          end
        end
        ST_HIGH: begin
          if (sigFall) begin
            highTime_q <= counter_q;
            counter_q  <= counter_q + CountOne;
            state_q    <= ST_LOW;
          end else if (atLimit) begin
            period_q   <= '0;
            highTime_q <= '0;
            timeout_q  <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            counter_q <= counter_q + CountOne;
          end
        end
        ST_LOW: begin
          if (sigRise) begin
            period_q  <= counter_q;
            timeout_q <= 1'b0;
            state_q   <= ST_DONE;
          end else if (atLimit) begin
            period_q   <= '0;
            highTime_q <= '0;
            timeout_q  <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            counter_q <= counter_q + CountOne;
          end
        end
        ST_DONE: begin
          if (meas_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          counter_q <= '0;
          state_q   <= ST_SETTLE;
        end
      endcase
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign meas_valid = (state_q == ST_DONE);
  assign period     = period_q;
  assign high_time  = highTime_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: two instances (long and short timeout)
// measure a generated waveform; expectations come from the waveform's own high/low lengths.
module tb_clk_period_meter;

  localparam int SYNC      = 2;
  localparam int TMO_LONG  = 1000;
  localparam int TMO_SHORT = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sig_in = 1'b0;
  logic        startS [2];
  logic        readyS [2];
  logic        busyS  [2];
  logic        validS [2];
  logic [31:0] periodS[2];
  logic [31:0] highS  [2];
  logic        toS    [2];

  int errors = 0;
  int checks = 0;

  int hiLen = 5;
  int loLen = 5;
  int phase = 0;
  bit sigHold = 1'b1;

  clk_period_meter #(.CNT_W(32), .SYNC_STAGES(SYNC), .TIMEOUT(TMO_LONG)) dutLong (
    .clk(clk), .reset(reset), .sig_in(sig_in), .start(startS[0]),
    .busy(busyS[0]), .meas_valid(validS[0]), .meas_ready(readyS[0]),
    .period(periodS[0]), .high_time(highS[0]), .timeout(toS[0])
  );

  clk_period_meter #(.CNT_W(32), .SYNC_STAGES(SYNC), .TIMEOUT(TMO_SHORT)) dutShort (
    .clk(clk), .reset(reset), .sig_in(sig_in), .start(startS[1]),
    .busy(busyS[1]), .meas_valid(validS[1]), .meas_ready(readyS[1]),
    .period(periodS[1]), .high_time(highS[1]), .timeout(toS[1])
  );

  always #5 clk = ~clk;

  // Waveform source: hiLen cycles high then loLen cycles low, changing on falling clk edges.
  always @(negedge clk) begin
    if (sigHold) begin
      sig_in = 1'b0;
      phase  = 0;
    end else begin
      sig_in = (phase < hiLen);
      phase  = (phase + 1 >= hiLen + loLen) ? 0 : phase + 1;
    end
  end

  function automatic int tmoOf(input int sel);
    return (sel == 0) ? TMO_LONG : TMO_SHORT;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int hi, input int lo, input bit hold);
    hiLen   = hi;
    loLen   = lo;
    sigHold = hold;
    repeat (150) step();
  endtask

  task automatic runMeasure(input int sel, output logic [31:0] p, output logic [31:0] h,
                            output logic to, output int waitCycles, output bit got);
    got        = 1'b0;
    waitCycles = 0;
    p          = '0;
    h          = '0;
    to         = 1'b0;
    step();
    startS[sel] = 1'b1;
    step();
    startS[sel] = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      if (validS[sel] === 1'b1) got = 1'b1;
      else begin
        step();
        waitCycles++;
      end
    end
    if (got) begin
      p  = periodS[sel];
      h  = highS[sel];
      to = toS[sel];
      readyS[sel] = 1'b1;
      step();
      readyS[sel] = 1'b0;
    end
  endtask

  task automatic checkSettle(input string tag);
    for (int k = 1; k <= SYNC + 1; k++) begin
      step();
      for (int s = 0; s < 2; s++) begin
        checks++;
        if (busyS[s] !== (k < SYNC + 1)) begin
          errors++;
          $display("[TB] FAIL %s_settle dut%0d cycle %0d: busy=%b expected %b",
                   tag, s, k, busyS[s], (k < SYNC + 1));
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (busyS[s] !== 1'b1 || validS[s] !== 1'b0 || periodS[s] !== 32'd0 ||
          highS[s] !== 32'd0 || toS[s] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_state dut%0d: busy=%b valid=%b period=%0d high=%0d to=%b expected 1 0 0 0 0",
                 s, busyS[s], validS[s], periodS[s], highS[s], toS[s]);
      end
    end
    checkSettle("reset");
  endtask

  task automatic test_basic();
    logic [31:0] p, h;
    logic to;
    int w;
    bit got;
    applyStimulus(5, 5, 1'b0);
    runMeasure(0, p, h, to, w, got);
    checks++;
    if (!got || p !== 32'd10 || h !== 32'd5 || to !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_10_5: got=%b period=%0d high=%0d to=%b expected period=10 high=5 to=0",
               got, p, h, to);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] p, h;
    logic to;
    int w;
    bit got;
    applyStimulus(3, 4, 1'b0);
    for (int n = 0; n < 5; n++) begin
      runMeasure(0, p, h, to, w, got);
      checks++;
      if (!got || p !== 32'd7 || h !== 32'd3 || to !== 1'b0) begin
        errors++;
        $display("[TB] FAIL back_to_back_%0d: got=%b period=%0d high=%0d to=%b expected period=7 high=3 to=0",
                 n, got, p, h, to);
      end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] p, h;
    logic to;
    int w;
    bit got;
    applyStimulus(0, 0, 1'b1);
    runMeasure(1, p, h, to, w, got);
    checks++;
    if (!got || p !== 32'd0 || h !== 32'd0 || to !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_flat: got=%b period=%0d high=%0d to=%b expected period=0 high=0 to=1",
               got, p, h, to);
    end
    checks++;
    if (w !== TMO_SHORT) begin
      errors++;
      $display("[TB] FAIL timeout_latency: waited %0d cycles expected %0d", w, TMO_SHORT);
    end
  endtask

  task automatic test_edge_wins();
    logic [31:0] p, h;
    logic to;
    int w;
    bit got;
    applyStimulus(25, 25, 1'b0);
    runMeasure(1, p, h, to, w, got);
    checks++;
    if (!got || p !== 32'd50 || h !== 32'd25 || to !== 1'b0) begin
      errors++;
      $display("[TB] FAIL edge_wins_50: got=%b period=%0d high=%0d to=%b expected period=50 high=25 to=0",
               got, p, h, to);
    end
    applyStimulus(26, 25, 1'b0);
    runMeasure(1, p, h, to, w, got);
    checks++;
    if (!got || p !== 32'd0 || h !== 32'd0 || to !== 1'b1) begin
      errors++;
      $display("[TB] FAIL just_over_51: got=%b period=%0d high=%0d to=%b expected period=0 high=0 to=1",
               got, p, h, to);
    end
  endtask

  task automatic test_hold_done();
    bit got = 1'b0;
    applyStimulus(5, 5, 1'b0);
    step();
    startS[0] = 1'b1;
    step();
    startS[0] = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      if (validS[0] === 1'b1) got = 1'b1;
      else step();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL hold_wait_valid: valid=%b expected 1 within 500 cycles", validS[0]);
    end
    for (int c = 0; c < 20; c++) begin
      startS[0] = c[0];
      step();
      checks++;
      if (validS[0] !== 1'b1 || busyS[0] !== 1'b1 || periodS[0] !== 32'd10 ||
          highS[0] !== 32'd5 || toS[0] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_stable cycle %0d: valid=%b busy=%b period=%0d high=%0d to=%b expected 1 1 10 5 0",
                 c, validS[0], busyS[0], periodS[0], highS[0], toS[0]);
      end
    end
    startS[0] = 1'b0;
    readyS[0] = 1'b1;
    step();
    readyS[0] = 1'b0;
    checks++;
    if (validS[0] !== 1'b0 || busyS[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_release: valid=%b busy=%b expected 0 0", validS[0], busyS[0]);
    end
    repeat (5) step();
    checks++;
    if (busyS[0] !== 1'b0 || periodS[0] !== 32'd10 || highS[0] !== 32'd5) begin
      errors++;
      $display("[TB] FAIL idle_hold: busy=%b period=%0d high=%0d expected 0 10 5",
               busyS[0], periodS[0], highS[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] p, h;
    logic to;
    int w;
    bit got;
    applyStimulus(5, 40, 1'b0);
    step();
    startS[0] = 1'b1;
    step();
    startS[0] = 1'b0;
    for (int i = 0; i < 200 && sig_in !== 1'b0; i++) step();
    for (int i = 0; i < 200 && sig_in !== 1'b1; i++) step();
    for (int i = 0; i < 200 && sig_in !== 1'b0; i++) step();
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (validS[0] !== 1'b0 || busyS[0] !== 1'b1 || periodS[0] !== 32'd0 ||
        highS[0] !== 32'd0 || toS[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_state: valid=%b busy=%b period=%0d high=%0d to=%b expected 0 1 0 0 0",
               validS[0], busyS[0], periodS[0], highS[0], toS[0]);
    end
    checkSettle("reset_mid");
    applyStimulus(5, 5, 1'b0);
    runMeasure(0, p, h, to, w, got);
    checks++;
    if (!got || p !== 32'd10 || h !== 32'd5 || to !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_remeasure: got=%b period=%0d high=%0d to=%b expected 10 5 0",
               got, p, h, to);
    end
  endtask

  task automatic test_random();
    logic [31:0] p, h, expP, expH;
    logic to, expTo;
    int w, sel, hi, lo;
    bit got, hold;
    for (int n = 0; n < 8; n++) begin
      sel  = int'($urandom_range(0, 1));
      hi   = int'($urandom_range(1, 30));
      lo   = int'($urandom_range(1, 30));
      hold = (sel == 1) && ($urandom_range(0, 4) == 0);
      expTo = hold || (hi + lo > tmoOf(sel));
      expP  = expTo ? 32'd0 : 32'(hi + lo);
      expH  = expTo ? 32'd0 : 32'(hi);
      applyStimulus(hi, lo, hold);
      runMeasure(sel, p, h, to, w, got);
      checks++;
      if (!got || p !== expP || h !== expH || to !== expTo) begin
        errors++;
        $display("[TB] FAIL random_%0d dut%0d hi=%0d lo=%0d hold=%b: got=%b period=%0d high=%0d to=%b expected %0d %0d %b",
                 n, sel, hi, lo, hold, got, p, h, to, expP, expH, expTo);
      end
    end
  endtask

  initial begin
    startS[0] = 1'b0;
    startS[1] = 1'b0;
    readyS[0] = 1'b0;
    readyS[1] = 1'b0;
    $display("[TB] clk_period_meter bench starting");
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_edge_wins();
    test_hold_done();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
